tt_sel_seq: RTL and testbench
=============================

# tt_sel_seq

Design-selection sequencer that drives the controller's three select pads: `ctrl_sel_rst_n`, `ctrl_sel_inc` and `ctrl_ena`. It accepts a target user-module address over a valid/ready request port. It then generates the disable / selector-reset / increment-pulse / settle / enable sequence needed to route the spine to that design. The block sits between a host-side command interface (SPI or management MCU bridge) and the `tt_ctrl` pad inputs, and replaces manual pad toggling.

## Interface
- `ADDR_W`, 10: address width; matches the spine address field.
- `MAX_ADDR`, 1023: highest legal design address.
- `PULSE_W`, 2: cycles per half-period of an increment pulse, and the selector-reset low time (≥1).
- `SETTLE`, 4: cycles `ctrl_ena` is held low before and after re-selection (≥1).

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: block idle; a request is accepted when `req_valid & req_ready`.
- `req_addr` in `ADDR_W`: target design address.
- `req_ena` in 1: value `ctrl_ena` takes once selection completes.
- `abort` in 1: cancel an in-flight sequence.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: qualifies `done`; set when the request was rejected.
- `busy` out 1: equal to `~req_ready`.
- `cur_addr` out `ADDR_W`: last successfully selected address.
- `cur_valid` out 1: `cur_addr` matches the selector state.
- `ctrl_sel_rst_n` out 1: to the pad input of the same name.
- `ctrl_sel_inc` out 1: to the pad input of the same name.
- `ctrl_ena` out 1: to the pad input of the same name.

## Operation
- Reset values:
  - `ctrl_sel_rst_n`=0, `ctrl_sel_inc`=0, `ctrl_ena`=0.
  - `req_ready`=0 while in reset, and 1 from the first clock edge after `rst_n` rises.
  - `done`=0, `err`=0, `cur_addr`=0, `cur_valid`=0.
- States: IDLE → DIS → RST → INC_HI ⇄ INC_LO → SET → ENA → IDLE.
- IDLE drives `ctrl_sel_rst_n`=1, `ctrl_sel_inc`=0, holds `ctrl_ena`, and asserts `req_ready`.
- On accept, the block latches `req_addr` and `req_ena`. The pulse count is loaded into an `ADDR_W`-bit down-counter.
- If `req_addr` > `MAX_ADDR`:
  - the next cycle is ENA with `done`=1 and `err`=1;
  - no pad activity occurs, and `cur_*` is unchanged.
- DIS: `ctrl_ena`=0 for `SETTLE` cycles.
- RST: `ctrl_sel_rst_n`=0 for `PULSE_W` cycles.
- INC_HI and INC_LO: `ctrl_sel_inc`=1 for `PULSE_W` cycles, then 0 for `PULSE_W` cycles. This repeats for each remaining pulse; with zero pulses, go straight to SET.
- SET: all pad outputs idle and `ctrl_ena`=0 for `SETTLE` cycles.
- ENA (one cycle):
  - `ctrl_ena` ← latched `req_ena`;
  - `done`=1, `err`=0;
  - `cur_addr` ← target, `cur_valid`=1.
- `abort` in any non-IDLE state: the next state is IDLE with `ctrl_ena`=0, `ctrl_sel_inc`=0, `ctrl_sel_rst_n`=1 and `cur_valid`=0. No `done` is pulsed. `abort` in IDLE is ignored.
- `req_valid` is ignored while busy; no queueing.
- `rst_n` low mid-sequence forces the reset values immediately.

## Timing
- Full path, accept in cycle 0: `done` is high in cycle 1+`SETTLE`+`PULSE_W`+2·`PULSE_W`·N+`SETTLE`, where N is the pulse count.
- `req_ready` returns high the cycle after `done`. A back-to-back request may be accepted in that cycle.
- Reject path: `done`/`err` are high in cycle 1.
- All pad outputs are registered; there is no combinational path from request inputs to pads.

## Configuration
- `TT_SEL_SEQ_INCR_EN` defined (incremental mode): when `cur_valid`=1 and `req_addr` ≥ `cur_addr`, the RST state is skipped and N = `req_addr`−`cur_addr`. The DIS and SET states still occur. Otherwise the full path is used with N = `req_addr`.
- Undefined: every request takes the full path with N = `req_addr`.

## Test plan
- Reset release, then `req_addr`=3, `req_ena`=1, with `PULSE_W`=2 and `SETTLE`=4:
  - exactly 3 `ctrl_sel_inc` pulses, each 2 cycles high and 2 cycles low;
  - `ctrl_sel_rst_n` low for 2 cycles;
  - `done` in cycle 23;
  - `ctrl_ena`=1, `cur_addr`=3.
- Request with `req_addr`=0: no inc pulses, `done` in cycle 11, `ctrl_ena` follows `req_ena`.
- `MAX_ADDR`=511, request with `req_addr`=600: `done`=`err`=1 in cycle 1, zero pad toggles, `cur_addr` unchanged.
- `abort` asserted during the 2nd INC_HI:
  - `ctrl_sel_inc` is 0 the next cycle;
  - `cur_valid`=0, `ctrl_ena`=0;
  - no `done`; `req_ready`=1.
- With `TT_SEL_SEQ_INCR_EN`, select 3 then 5: the second sequence has no RST low phase, 2 pulses, and `done` in cycle 17. Then select 1: full path with a reset and 1 pulse.
- `rst_n` pulsed low mid-INC: all outputs go to their reset values asynchronously, and `cur_valid`=0.

Source files
------------

// File: rtl/tt_sel_seq.sv
// Drives the tt_ctrl select pads (disable, selector reset, inc pulses, settle, enable) to route the spine to a requested design.
// Define TT_SEL_SEQ_INCR_EN to step forward from the current selection without a selector reset when possible.
module tt_sel_seq #(
  parameter int ADDR_W   = 10,
  parameter int MAX_ADDR = 1023,
  parameter int PULSE_W  = 2,
  parameter int SETTLE   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_ena,
  input  logic              abort,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              cur_valid,
  output logic              ctrl_sel_rst_n,
  output logic              ctrl_sel_inc,
  output logic              ctrl_ena
);

  typedef enum logic [2:0] {
    S_IDLE, S_DIS, S_RST, S_INC_HI, S_INC_LO, S_SET, S_ENA
  } state_t;

  localparam logic [ADDR_W:0] MAX_A = (ADDR_W+1)'(MAX_ADDR);
  localparam logic [15:0]     T_SET = 16'(SETTLE - 1);
  localparam logic [15:0]     T_PW  = 16'(PULSE_W - 1);

  state_t            state_q, state_d;
  logic [15:0]       tmr_q, tmr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] tgt_q;
  logic              ena_q, skip_q;
  logic              accept, rej_now, skip_now, abort_hit, sel_ok, pad_quiet;
  logic [ADDR_W-1:0] n_now;
  logic [ADDR_W:0]   max_diff;

  assign accept   = req_valid & req_ready;
  assign busy     = ~req_ready;
  // Borrow out of MAX_ADDR - addr flags an out-of-range address.
  assign max_diff = MAX_A - {1'b0, req_addr};
  assign rej_now  = max_diff[ADDR_W];

`ifdef TT_SEL_SEQ_INCR_EN
  assign skip_now = cur_valid & (req_addr >= cur_addr);
  assign n_now    = skip_now ? (req_addr - cur_addr) : req_addr;
`else
  assign skip_now = 1'b0;
  assign n_now    = req_addr;
`endif

  assign abort_hit = abort & (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q - 16'd1;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        tmr_d = tmr_q;
        if (accept) begin
          cnt_d = n_now;
          if (rej_now) begin
            state_d = S_ENA;
          end else begin
            state_d = S_DIS;
            tmr_d   = T_SET;
          end
        end
      end
      S_DIS: if (tmr_q == '0) begin
        if (!skip_q)           begin state_d = S_RST;    tmr_d = T_PW;  end
        else if (cnt_q == '0)  begin state_d = S_SET;    tmr_d = T_SET; end
        else                   begin state_d = S_INC_HI; tmr_d = T_PW;  end
      end
      S_RST: if (tmr_q == '0) begin
        if (cnt_q == '0) begin state_d = S_SET;    tmr_d = T_SET; end
        else             begin state_d = S_INC_HI; tmr_d = T_PW;  end
      end
      S_INC_HI: if (tmr_q == '0) begin
        state_d = S_INC_LO;
        tmr_d   = T_PW;
      end
      S_INC_LO: if (tmr_q == '0) begin
        cnt_d = cnt_q - ADDR_W'(1);
        if (cnt_q == ADDR_W'(1)) begin state_d = S_SET;    tmr_d = T_SET; end
        else                     begin state_d = S_INC_HI; tmr_d = T_PW;  end
      end
      S_SET: if (tmr_q == '0) state_d = S_ENA;
      S_ENA:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_hit) state_d = S_IDLE;
  end

  // ENA reached from SET is a real selection; ENA straight from IDLE is a reject.
  assign sel_ok    = (state_d == S_ENA) && (state_q == S_SET);
  assign pad_quiet = (state_d == S_DIS) || (state_d == S_RST) || (state_d == S_INC_HI) ||
                     (state_d == S_INC_LO) || (state_d == S_SET);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      tmr_q          <= '0;
      cnt_q          <= '0;
      tgt_q          <= '0;
      ena_q          <= 1'b0;
      skip_q         <= 1'b0;
      req_ready      <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      cur_addr       <= '0;
      cur_valid      <= 1'b0;
      ctrl_sel_rst_n <= 1'b0;
      ctrl_sel_inc   <= 1'b0;
      ctrl_ena       <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        tgt_q  <= req_addr;
        ena_q  <= req_ena;
        skip_q <= skip_now;
      end
      // Pads and status are registered from the next state so they line up with it.
      req_ready      <= (state_d == S_IDLE);
      done           <= (state_d == S_ENA);
      err            <= (state_d == S_ENA) && (state_q == S_IDLE);
      ctrl_sel_rst_n <= (state_d != S_RST);
      ctrl_sel_inc   <= (state_d == S_INC_HI);
      if (pad_quiet || abort_hit) ctrl_ena <= 1'b0;
      else if (sel_ok)            ctrl_ena <= ena_q;
      if (sel_ok) begin
        cur_addr  <= tgt_q;
        cur_valid <= 1'b1;
      end else if (abort_hit) begin
        cur_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tt_sel_seq.sv
module tb_tt_sel_seq;
  localparam int AW = 10, MAXA = 511, PW = 2, ST = 4;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          req_valid = 1'b0, req_ena = 1'b0, abort = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic          req_ready, done, err, busy, cur_valid;
  logic          ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena;
  logic [AW-1:0] cur_addr;

  tt_sel_seq #(.ADDR_W(AW), .MAX_ADDR(MAXA), .PULSE_W(PW), .SETTLE(ST)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_ena(req_ena), .abort(abort), .done(done), .err(err),
    .busy(busy), .cur_addr(cur_addr), .cur_valid(cur_valid),
    .ctrl_sel_rst_n(ctrl_sel_rst_n), .ctrl_sel_inc(ctrl_sel_inc), .ctrl_ena(ctrl_ena)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lat; bit err; int pulses; int rstlow; bit ena; int addr; bit cval;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0;
  int   m_addr = 0;
  bit   m_valid = 0, m_ena = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected outcome of one request, from the selection rules and the current selection.
  function automatic exp_t model(int a, bit e);
    exp_t x;
    bit   full;
    int   n;
    if (a > MAXA) begin
      x.lat = 1; x.err = 1; x.pulses = 0; x.rstlow = 0;
      x.ena = m_ena; x.addr = m_addr; x.cval = m_valid;
      return x;
    end
    full = 1;
    n    = a;
`ifdef TT_SEL_SEQ_INCR_EN
    if (m_valid && a >= m_addr) begin
      full = 0;
      n    = a - m_addr;
    end
`endif
    x.lat    = 1 + ST + (full ? PW : 0) + 2 * PW * n + ST;
    x.err    = 0;
    x.pulses = n;
    x.rstlow = full ? PW : 0;
    x.ena    = e;
    x.addr   = a;
    x.cval   = 1;
    return x;
  endfunction

  // Monitor: measures pad activity per request and checks it when done appears.
  int   acc_cyc = 0, pulses = 0, rstlow = 0, hirun = 0;
  bit   prev_inc = 0;
  exp_t got;
  always @(negedge clk) begin
    if (!rst_n) begin
      pulses = 0; rstlow = 0; hirun = 0; prev_inc = 0;
    end else begin
      if (req_valid && req_ready) begin
        acc_cyc = cyc; pulses = 0; rstlow = 0;
      end
      if (ctrl_sel_inc) begin
        if (!prev_inc) pulses++;
        hirun++;
      end else if (prev_inc) begin
        chk("inc_high_width", hirun, PW);
        hirun = 0;
      end
      prev_inc = ctrl_sel_inc;
      if (!ctrl_sel_rst_n) rstlow++;
      if (abort) begin
        prev_inc = 0; hirun = 0;
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          got = sb.pop_front();
          chk("done_latency", cyc - acc_cyc, got.lat);
          chk("err",          int'(err), int'(got.err));
          chk("inc_pulses",   pulses, got.pulses);
          chk("rst_low_cyc",  rstlow, got.rstlow);
          chk("ctrl_ena",     int'(ctrl_ena), int'(got.ena));
          chk("cur_addr",     int'(cur_addr), got.addr);
          chk("cur_valid",    int'(cur_valid), int'(got.cval));
        end
      end
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (req_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("ready_timeout", 0, 1);
  endtask

  task automatic issue(int a, bit e, bit push);
    bit   ok;
    exp_t x;
    wait_ready(ok);
    if (!ok) return;
    req_valid = 1'b1;
    req_addr  = AW'(a);
    req_ena   = e;
    if (push) begin
      x = model(a, e);
      sb.push_back(x);
      if (!x.err) begin
        m_addr = a; m_valid = 1; m_ena = e;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int i;
    for (i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && req_ready) break;
    end
    if (i == 3000) chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit full;
    int off;
    int a;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_busy",      int'(busy), 1);
    chk("rst_sel_rst_n", int'(ctrl_sel_rst_n), 0);
    chk("rst_sel_inc",   int'(ctrl_sel_inc), 0);
    chk("rst_ena",       int'(ctrl_ena), 0);
    chk("rst_done",      int'(done), 0);
    chk("rst_err",       int'(err), 0);
    chk("rst_cur_addr",  int'(cur_addr), 0);
    chk("rst_cur_valid", int'(cur_valid), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", int'(req_ready), 1);
    chk("idle_sel_rst_n",  int'(ctrl_sel_rst_n), 1);

    issue(3, 1, 1);
    issue(0, 0, 1);
    issue(600, 1, 1);
    issue(3, 1, 1);
    issue(5, 0, 1);
    issue(1, 1, 1);
    wait_drain();

    // Abort in the second increment-high phase of a selection of 5.
    full = 1;
`ifdef TT_SEL_SEQ_INCR_EN
    if (m_valid && 5 >= m_addr) full = 0;
`endif
    off = 1 + ST + (full ? PW : 0) + 2 * PW;
    issue(5, 1, 0);
    repeat (off - 1) @(posedge clk);
    #1;
    chk("abort_pre_inc", int'(ctrl_sel_inc), 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_inc",       int'(ctrl_sel_inc), 0);
    chk("abort_cur_valid", int'(cur_valid), 0);
    chk("abort_ena",       int'(ctrl_ena), 0);
    chk("abort_ready",     int'(req_ready), 1);
    chk("abort_done",      int'(done), 0);
    m_valid = 0;
    m_ena   = 0;
    repeat (20) @(posedge clk);

    // Asynchronous reset in the middle of the increment phase.
    issue(6, 1, 1);
    repeat (9) @(posedge clk);
    #3;
    chk("pre_rst_in_inc", int'(ctrl_sel_rst_n), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_sel_inc",   int'(ctrl_sel_inc), 0);
    chk("arst_sel_rst_n", int'(ctrl_sel_rst_n), 0);
    chk("arst_ena",       int'(ctrl_ena), 0);
    chk("arst_ready",     int'(req_ready), 0);
    chk("arst_cur_valid", int'(cur_valid), 0);
    chk("arst_done",      int'(done), 0);
    sb.delete();
    m_valid = 0; m_addr = 0; m_ena = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 30; i++) begin
      a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(512, 1023)) : int'($urandom_range(0, 40));
      issue(a, 1'($urandom_range(0, 1)), 1);
    end
    wait_drain();
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
